pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
- Consumes the Gowin PLL's asynchronous `lock` output and turns it into a clean, synchronous system reset for logic clocked by the PLL outputs.
- Runs on the crystal reference clock (the PLL input clock), never on a PLL output, so it keeps working while the PLL is unlocked.
- Filters lock glitches, enforces a stabilisation window and reset hold, and counts lock-loss events.
- Requests a PLL reset if lock is never achieved within a timeout.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising `pll_lock`; minimum 2.
- STABLE_CYCLES, 1024: consecutive `lock_s`=1 cycles needed before the reset hold starts.
- HOLD_CYCLES, 16: extra cycles `sys_rst` stays high after stabilisation.
- LOSS_FILTER, 4: consecutive `lock_s`=0 cycles in RUN that count as a real loss.
- TIMEOUT_CYCLES, 65536: cycles in WAIT_LOCK before a PLL reset is requested.
- PLL_RST_CYCLES, 8: width in cycles of the `pll_rst` pulse.
- CNT_W, 8: width of `loss_count`.

Ports:
- clk  in  1  crystal reference clock, same net as the PLL `clkin`.
- rst  in  1  asynchronous, active-high reset.
- pll_lock  in  1  raw PLL lock output; asynchronous to `clk`.
- pll_rst  out  1  active-high reset request, wired to the PLL RESET pin.
- sys_rst  out  1  active-high synchronous reset for downstream logic.
- ready  out  1  high only in RUN.
- loss_count  out  CNT_W  saturating count of lock-loss events.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset values (while `rst`=1): FSM=WAIT_LOCK, `sys_rst`=1, `ready`=0, `pll_rst`=0, `loss_count`=0, synchroniser flops=0, all counters=0.
- Synchroniser: `lock_s` = `pll_lock` delayed through SYNC_STAGES flops. It is the only signal the FSM reads.
- WAIT_LOCK:
  - Outputs: `sys_rst`=1, `ready`=0. The timeout counter increments each cycle.
  - If `lock_s`=1: go to STABILIZE and clear the timeout counter.
  - If the counter reaches TIMEOUT_CYCLES-1 with `lock_s`=0: go to PLL_RESET.
  - If `lock_s`=1 in that same cycle, the lock wins.
- PLL_RESET:
  - Outputs: `pll_rst`=1, `sys_rst`=1.
  - Stays for exactly PLL_RST_CYCLES cycles, then returns to WAIT_LOCK with the timeout counter cleared.
  - `lock_s` is ignored in this state.
- STABILIZE:
  - Outputs: `sys_rst`=1.
  - The counter increments while `lock_s`=1.
  - Any `lock_s`=0 returns to WAIT_LOCK with the counter cleared. This is not counted as a loss.
  - After STABLE_CYCLES consecutive high cycles, go to HOLD.
- HOLD:
  - Outputs: `sys_rst`=1.
  - Lasts HOLD_CYCLES cycles, then goes to RUN.
  - `lock_s`=0 during HOLD returns to WAIT_LOCK immediately. No loss is counted.
- RUN:
  - Outputs: `sys_rst`=0, `ready`=1.
  - The low-run counter increments while `lock_s`=0 and clears on `lock_s`=1.
  - When it reaches LOSS_FILTER: go to WAIT_LOCK, and on that same edge assert `sys_rst`=1 and increment `loss_count`.
  - Glitches shorter than LOSS_FILTER cycles are invisible downstream.
- Latency: `sys_rst` falls exactly SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES clocks after the first `clk` edge that samples `pll_lock`=1, assuming lock stays high.
- Registered outputs: all outputs come from flops. `sys_rst` and `ready` are never high together and never both low.
- `loss_count` saturates at 2^CNT_W-1 and clears only on `rst`.
- `rst` asserted mid-operation forces the reset values asynchronously. When `rst` is released, the sequence restarts from WAIT_LOCK and stabilisation is re-qualified.
- State encoding: WAIT_LOCK=0, PLL_RESET=1, STABILIZE=2, HOLD=3, RUN=4.
- Counter width: one shared counter sized to clog2 of the largest of TIMEOUT_CYCLES, STABLE_CYCLES, HOLD_CYCLES and PLL_RST_CYCLES. The LOSS_FILTER counter is separate.

Decomposition:
- Package `pll_sup_pkg`:
  - state enum `pll_sup_state_t` with the encodings above;
  - a clog2-based width helper function.
- Sub-module `sync_ff`: a parameterised N-stage synchroniser with async active-high reset. It is reused elsewhere for the `lock` crossing.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, LOSS_FILTER=3, TIMEOUT_CYCLES=32, PLL_RST_CYCLES=8):
- Clean lock: release `rst`, raise `pll_lock` at edge N and hold it → `sys_rst` falls and `ready` rises at edge N+14; `loss_count`=0.
- Glitch filtering: in RUN, drive `pll_lock` low for 2 cycles → `sys_rst` stays 0 and `loss_count`=0. Then drive it low for 3 cycles → `sys_rst`=1 and `loss_count`=1; after relock, `ready` returns 14 cycles after the relock sample.
- Unstable lock: toggle `pll_lock` high 5 cycles, low 1, high → STABILIZE restarts; `sys_rst` deasserts 14 cycles after the final rise; `loss_count`=0.
- Timeout: hold `pll_lock`=0 after reset → `pll_rst` high for exactly 8 cycles starting 32 cycles after `rst` release, repeating every 40 cycles.
- Saturation: CNT_W=2, force 5 loss events → `loss_count` sticks at 3.
- Reset mid-HOLD: assert `rst` during HOLD → outputs return to reset values asynchronously; with `pll_lock` still high, `ready` returns 14 cycles after `rst` release.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  // Supervisor FSM states. The encoding is visible on state_o for debug.
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    PLL_RESET = 3'd1,
    STABILIZE = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } pll_sup_state_t;

  // Width of a counter that must hold values 0 .. max(a,b,c,d)-1.
  // Never returns less than 1.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchroniser for a single asynchronous bit.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  // Shift the raw input through the chain; the last stage is the clean copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_reg <= '0;
    else     stage_reg <= {stage_reg[STAGES-2:0], d};
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Turns the asynchronous PLL lock flag into a filtered, qualified system
// reset. Runs on the reference clock so it keeps working while unlocked.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int LOSS_FILTER    = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int PLL_RST_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic [2:0]       state_o
);

  // One counter is shared by the timeout, pll-reset, stabilise and hold phases.
  localparam int CW = cnt_width(TIMEOUT_CYCLES, STABLE_CYCLES, HOLD_CYCLES, PLL_RST_CYCLES);
  localparam int LW = cnt_width(LOSS_FILTER, 1, 1, 1);

  logic             lock_s;
  pll_sup_state_t   state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [LW-1:0]    low_reg, low_next;
  logic [CNT_W-1:0] loss_reg, loss_next;
  logic             sys_rst_reg, ready_reg, pll_rst_reg;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Next-state, phase counter, loss filter and loss counter decisions.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    low_next   = low_reg;
    loss_next  = loss_reg;
    case (state_reg)
      WAIT_LOCK: begin
        // A lock seen on the timeout cycle still wins.
        if (lock_s) begin
          state_next = STABILIZE;
          cnt_next   = '0;
        end else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
          state_next = PLL_RESET;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PLL_RESET: begin
        if (cnt_reg == CW'(PLL_RST_CYCLES - 1)) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == CW'(STABLE_CYCLES - 1)) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == CW'(HOLD_CYCLES - 1)) begin
          state_next = RUN;
          cnt_next   = '0;
          low_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RUN: begin
        // Only LOSS_FILTER consecutive low samples count as a real loss.
        if (lock_s) begin
          low_next = '0;
        end else if (low_reg == LW'(LOSS_FILTER - 1)) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
          low_next   = '0;
          if (loss_reg != {CNT_W{1'b1}}) loss_next = loss_reg + 1'b1;
        end else begin
          low_next = low_reg + 1'b1;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
        low_next   = '0;
      end
    endcase
  end

  // State and counters; outputs are registered from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= WAIT_LOCK;
      cnt_reg     <= '0;
      low_reg     <= '0;
      loss_reg    <= '0;
      sys_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
      pll_rst_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      low_reg     <= low_next;
      loss_reg    <= loss_next;
      sys_rst_reg <= (state_next != RUN);
      ready_reg   <= (state_next == RUN);
      pll_rst_reg <= (state_next == PLL_RESET);
    end
  end

  assign sys_rst    = sys_rst_reg;
  assign ready      = ready_reg;
  assign pll_rst    = pll_rst_reg;
  assign loss_count = loss_reg;
  assign state_o    = state_reg;

endmodule
